bypass_scoreboard: RTL and testbench

Parametrised operand-forwarding and hazard unit for the in-order core pipeline, sitting between decode (ID) and execute (EX). It resolves forwarding sources one cycle early in ID and registers the select per operand into EX. It tracks outstanding long-latency load misses in a per-register busy scoreboard, and generates load-use, RAW and WAW stalls. It extends the combinational bypass logic with N operand channels, registered selects, fill-data capture and miss tracking.

---
 rtl/bypass_scoreboard_pkg.sv | 28 ++
 rtl/bypass_src_resolve.sv | 78 +++++++
 rtl/bypass_scoreboard.sv | 225 ++++++++++++++++++++++
 tb/tb_bypass_scoreboard.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_scoreboard_pkg
//  Description : Shared core definitions for the operand-forwarding and
//                hazard unit: forward-select encoding, register index width
//                derivation and the default outstanding-miss depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package bypass_scoreboard_pkg;

   // Source of an EX operand; NONE means the register file value is used.
   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_MEM   = 2'd1,
      SEL_WBH   = 2'd2,
      SEL_FILLH = 2'd3
   } fwd_sel_e;

   localparam int c_NUM_REGS_DEFAULT    = 32;
   localparam int c_MAX_PENDING_DEFAULT = 4;

   // Register index width; a single-entry file still needs one index bit.
   function automatic int regWidth(input int numRegs);
      return (numRegs > 1) ? $clog2(numRegs) : 1;
   endfunction

endpackage : bypass_scoreboard_pkg
`default_nettype wire

// File: rtl/bypass_src_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_src_resolve
//  Description : Combinational priority resolver for one source operand in
//                ID. Picks the forwarding source the operand will use in EX
//                and flags load-use / RAW hazards and hold-register captures.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_src_resolve #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs,
   input  logic             rsUsed,
   input  logic             rsBusy,
   input  logic             exValid,
   input  logic [REG_W-1:0] exRd,
   input  logic             exWr,
   input  logic             exIsLoad,
   input  logic             memValid,
   input  logic [REG_W-1:0] memRd,
   input  logic             memWr,
   input  logic             wbValid,
   input  logic [REG_W-1:0] wbRd,
   input  logic             wbWr,
   input  logic             fillValid,
   input  logic [REG_W-1:0] fillRd,
   output logic [1:0]       nextSel,
   output logic             loadUse,
   output logic             rawStall,
   output logic             capMem,
   output logic             capWb,
   output logic             capFill
);
   import bypass_scoreboard_pkg::*;

   logic w_live;
   logic w_exHit;
   logic w_memHit;
   logic w_wbHit;
   logic w_fillHit;

   // r0 is hard-wired zero and unread operands never forward or stall.
   assign w_live    = rsUsed && (rs != '0);
   assign w_exHit   = w_live && exValid  && exWr  && (exRd  == rs);
   assign w_memHit  = w_live && memValid && memWr && (memRd == rs);
   assign w_wbHit   = w_live && wbValid  && wbWr  && (wbRd  == rs);
   assign w_fillHit = w_live && fillValid && (fillRd == rs);

   // Youngest producer wins; a same-cycle fill beats the busy bit.
   always_comb begin
      nextSel  = SEL_NONE;
      loadUse  = 1'b0;
      rawStall = 1'b0;
      capMem   = 1'b0;
      capWb    = 1'b0;
      capFill  = 1'b0;
      if (w_exHit) begin
         if (exIsLoad) begin
            loadUse = 1'b1;
         end else begin
            nextSel = SEL_MEM;
         end
      end else if (w_memHit) begin
         nextSel = SEL_WBH;
         capMem  = 1'b1;
      end else if (w_wbHit) begin
         nextSel = SEL_WBH;
         capWb   = 1'b1;
      end else if (w_fillHit) begin
         nextSel = SEL_FILLH;
         capFill = 1'b1;
      end else if (w_live && rsBusy) begin
         rawStall = 1'b1;
      end
   end

endmodule : bypass_src_resolve
`default_nettype wire

// File: rtl/bypass_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_scoreboard
//  Description : Operand-forwarding and hazard unit between ID and EX.
//                Resolves forwarding in ID, registers per-operand selects
//                into EX, holds WB/fill data, tracks outstanding load misses
//                in a busy scoreboard and merges load-use/RAW/WAW stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_scoreboard
   import bypass_scoreboard_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NUM_REGS    = c_NUM_REGS_DEFAULT,
   parameter int REG_W       = regWidth(NUM_REGS),
   parameter int NUM_SRC     = 2,
   parameter int MAX_PENDING = c_MAX_PENDING_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [NUM_SRC*REG_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]      id_rs_used,
   input  logic [REG_W-1:0]        id_rd,
   input  logic                    id_wr,
   input  logic                    ex_valid,
   input  logic [REG_W-1:0]        ex_rd,
   input  logic                    ex_wr,
   input  logic                    ex_is_load,
   input  logic                    mem_valid,
   input  logic [REG_W-1:0]        mem_rd,
   input  logic                    mem_wr,
   input  logic [XLEN-1:0]         mem_result,
   input  logic                    wb_valid,
   input  logic [REG_W-1:0]        wb_rd,
   input  logic                    wb_wr,
   input  logic [XLEN-1:0]         wb_result,
   input  logic                    miss_valid,
   input  logic [REG_W-1:0]        miss_rd,
   input  logic                    fill_valid,
   input  logic [REG_W-1:0]        fill_rd,
   input  logic [XLEN-1:0]         fill_data,
   output logic [NUM_SRC*2-1:0]    fwd_sel,
   output logic [NUM_SRC*XLEN-1:0] fwd_data,
   output logic                    stall,
   output logic                    pending_full,
   output logic                    err
);

   localparam int               c_CNT_W    = $clog2(MAX_PENDING + 1);
   localparam logic [c_CNT_W-1:0] c_PEND_MAX = c_CNT_W'(MAX_PENDING);
   localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

   // Scoreboard and hold state
   logic [NUM_REGS-1:0]    r_busy;
   logic [c_CNT_W-1:0]     r_count;
   logic                   r_pendingFull;
   logic                   r_err;
   logic [XLEN-1:0]        r_wbHold;
   logic [XLEN-1:0]        r_fillHold;
   logic [NUM_SRC*2-1:0]   r_fwdSel;

   // Per-source resolver results
   logic [1:0]             w_nextSel [NUM_SRC];
   logic [NUM_SRC-1:0]     w_rsBusy;
   logic [NUM_SRC-1:0]     w_loadUse;
   logic [NUM_SRC-1:0]     w_raw;
   logic [NUM_SRC-1:0]     w_capMem;
   logic [NUM_SRC-1:0]     w_capWb;
   logic [NUM_SRC-1:0]     w_capFill;

   // Merged hazard and scoreboard update terms
   logic                   w_conflict;
   logic                   w_waw;
   logic                   w_stall;
   logic                   w_missAcc;
   logic                   w_missFull;
   logic                   w_fillAcc;
   logic [NUM_REGS-1:0]    w_busyNext;
   logic [c_CNT_W-1:0]     w_countNext;

   // ------------------------------------------------------------------------
   // One priority resolver per source operand
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
         assign w_rsBusy[g] = r_busy[id_rs[g*REG_W +: REG_W]];

         bypass_src_resolve #(
            .REG_W (REG_W)
         ) u_resolve (
            .rs        (id_rs[g*REG_W +: REG_W]),
            .rsUsed    (id_rs_used[g]),
            .rsBusy    (w_rsBusy[g]),
            .exValid   (ex_valid),
            .exRd      (ex_rd),
            .exWr      (ex_wr),
            .exIsLoad  (ex_is_load),
            .memValid  (mem_valid),
            .memRd     (mem_rd),
            .memWr     (mem_wr),
            .wbValid   (wb_valid),
            .wbRd      (wb_rd),
            .wbWr      (wb_wr),
            .fillValid (fill_valid),
            .fillRd    (fill_rd),
            .nextSel   (w_nextSel[g]),
            .loadUse   (w_loadUse[g]),
            .rawStall  (w_raw[g]),
            .capMem    (w_capMem[g]),
            .capWb     (w_capWb[g]),
            .capFill   (w_capFill[g])
         );
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Stall merge
   // ------------------------------------------------------------------------
   // wb_hold is a single register: a MEM-sourced and a WB-sourced operand
   // cannot both be satisfied by it, so that pairing stalls instead.
   assign w_conflict = (|w_capMem) && (|w_capWb);

   // Writing a register whose miss is still outstanding would be overwritten
   // by the late fill, unless that fill lands this very cycle.
   assign w_waw = id_wr && r_busy[id_rd] && !(fill_valid && (fill_rd == id_rd));

   assign w_stall = !rst && id_valid &&
                    ((|w_loadUse) || (|w_raw) || w_waw || w_conflict);

   assign stall = w_stall;

   // Select register: bubble EX on a stall or an empty ID slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwdSel <= '0;
      end else if (w_stall || !id_valid) begin
         r_fwdSel <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            r_fwdSel[i*2 +: 2] <= w_nextSel[i];
         end
      end
   end

   // Hold registers: MEM value wins because that producer is the younger one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbHold   <= '0;
         r_fillHold <= '0;
      end else begin
         if (|w_capMem) begin
            r_wbHold <= mem_result;
         end else if (|w_capWb) begin
            r_wbHold <= wb_result;
         end
         if (|w_capFill) begin
            r_fillHold <= fill_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Miss scoreboard
   // ------------------------------------------------------------------------
   assign w_missAcc  = miss_valid && (miss_rd != '0) && (r_count != c_PEND_MAX);
   assign w_missFull = miss_valid && (miss_rd != '0) && (r_count == c_PEND_MAX);
   assign w_fillAcc  = fill_valid && r_busy[fill_rd];

   // Next busy vector and count; a fill and a miss together leave count as is.
   always_comb begin
      w_busyNext  = r_busy;
      w_countNext = r_count;
      if (w_fillAcc) begin
         w_busyNext[fill_rd] = 1'b0;
      end
      if (w_missAcc) begin
         w_busyNext[miss_rd] = 1'b1;
      end
      case ({w_missAcc, w_fillAcc})
         2'b10:   w_countNext = r_count + c_ONE;
         2'b01:   w_countNext = r_count - c_ONE;
         default: w_countNext = r_count;
      endcase
   end

   // Scoreboard state, full flag aligned with count, sticky overflow error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy        <= '0;
         r_count       <= '0;
         r_pendingFull <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_busy        <= w_busyNext;
         r_count       <= w_countNext;
         r_pendingFull <= (w_countNext == c_PEND_MAX);
         if (w_missFull) begin
            r_err <= 1'b1;
         end
      end
   end

   assign pending_full = r_pendingFull;
   assign err          = r_err;

   // ------------------------------------------------------------------------
   // EX operand data mux; NONE drives zero (consumer uses the register file).
   // ------------------------------------------------------------------------
   always_comb begin
      fwd_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         case (r_fwdSel[i*2 +: 2])
            SEL_MEM:   fwd_data[i*XLEN +: XLEN] = mem_result;
            SEL_WBH:   fwd_data[i*XLEN +: XLEN] = r_wbHold;
            SEL_FILLH: fwd_data[i*XLEN +: XLEN] = r_fillHold;
            default:   fwd_data[i*XLEN +: XLEN] = '0;
         endcase
      end
   end

   assign fwd_sel = r_fwdSel;

endmodule : bypass_scoreboard
`default_nettype wire

// File: tb/tb_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bypass_scoreboard
//  Description : Directed self-checking bench for bypass_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_wr;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_wr;
   logic        ex_is_load;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic        mem_wr;
   logic [31:0] mem_result;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_wr;
   logic [31:0] wb_result;
   logic        miss_valid;
   logic [4:0]  miss_rd;
   logic        fill_valid;
   logic [4:0]  fill_rd;
   logic [31:0] fill_data;
   logic [3:0]  fwd_sel;
   logic [63:0] fwd_data;
   logic        stall;
   logic        pending_full;
   logic        err;

   int nTotal = 0;
   int nBad   = 0;

   bypass_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_wr        (id_wr),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_wr        (ex_wr),
      .ex_is_load   (ex_is_load),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_result   (mem_result),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_wr        (wb_wr),
      .wb_result    (wb_result),
      .miss_valid   (miss_valid),
      .miss_rd      (miss_rd),
      .fill_valid   (fill_valid),
      .fill_rd      (fill_rd),
      .fill_data    (fill_data),
      .fwd_sel      (fwd_sel),
      .fwd_data     (fwd_data),
      .stall        (stall),
      .pending_full (pending_full),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nTotal++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wr = 0;
      ex_valid = 0; ex_rd = '0; ex_wr = 0; ex_is_load = 0;
      mem_valid = 0; mem_rd = '0; mem_wr = 0; mem_result = '0;
      wb_valid = 0; wb_rd = '0; wb_wr = 0; wb_result = '0;
      miss_valid = 0; miss_rd = '0;
      fill_valid = 0; fill_rd = '0; fill_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset ----------------
      rst = 1; idle();
      step();
      ex_valid = 1; ex_rd = 5'd7; ex_wr = 1; ex_is_load = 1;
      id_valid = 1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      #1 chk("rst_stall", stall, 0);
      step();
      chk("rst_sel", fwd_sel, 0);
      chk("rst_pfull", pending_full, 0);
      chk("rst_err", err, 0);
      chk("rst_count", dut.r_count, 0);
      chk("rst_busy", dut.r_busy, 0);
      rst = 0; idle();

      // ---------------- ALU chain EX->MEM ----------------
      ex_valid = 1; ex_rd = 5'd5; ex_wr = 1;
      id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
      #1 chk("alu_stall", stall, 0);
      step();
      idle(); mem_result = 32'h1234;
      #1 chk("alu_sel0", fwd_sel[1:0], 1);
      chk("alu_sel1", fwd_sel[3:2], 0);
      chk("alu_data0", fwd_data[31:0], 32'h1234);

      // ---------------- unused source never stalls ----------------
      idle();
      ex_valid = 1; ex_rd = 5'd7; ex_wr = 1; ex_is_load = 1;
      id_valid = 1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b00;
      #1 chk("unused_stall", stall, 0);

      // ---------------- load-use ----------------
      id_rs_used = 2'b01;
      #1 chk("lu_stall", stall, 1);
      step();
      chk("lu_bubble", fwd_sel, 0);
      ex_valid = 0; ex_rd = '0; ex_wr = 0; ex_is_load = 0;
      mem_valid = 1; mem_rd = 5'd7; mem_wr = 1; mem_result = 32'hCAFE;
      #1 chk("lu_release", stall, 0);
      step();
      idle(); mem_result = 32'hDEAD;
      #1 chk("lu_sel", fwd_sel[1:0], 2);
      chk("lu_data", fwd_data[31:0], 32'hCAFE);

      // ---------------- priority EX over WB ----------------
      idle();
      ex_valid = 1; ex_rd = 5'd3; ex_wr = 1;
      wb_valid = 1; wb_rd = 5'd3; wb_wr = 1; wb_result = 32'h77;
      id_valid = 1; id_rs = {5'd3, 5'd0}; id_rs_used = 2'b10;
      #1 chk("prio_stall", stall, 0);
      step();
      idle(); mem_result = 32'h3333;
      #1 chk("prio_sel1", fwd_sel[3:2], 1);
      chk("prio_sel0", fwd_sel[1:0], 0);
      chk("prio_data1", fwd_data[63:32], 32'h3333);

      // ---------------- WB forward via hold ----------------
      idle();
      wb_valid = 1; wb_rd = 5'd12; wb_wr = 1; wb_result = 32'h5A5A;
      id_valid = 1; id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
      #1 chk("wb_stall", stall, 0);
      step();
      idle();
      #1 chk("wb_sel", fwd_sel[1:0], 2);
      chk("wb_data", fwd_data[31:0], 32'h5A5A);

      // ---------------- MEM and WB need different hold values ----------------
      idle();
      mem_valid = 1; mem_rd = 5'd10; mem_wr = 1; mem_result = 32'h1111;
      wb_valid = 1; wb_rd = 5'd11; wb_wr = 1; wb_result = 32'h2222;
      id_valid = 1; id_rs = {5'd11, 5'd10}; id_rs_used = 2'b11;
      #1 chk("conf_stall", stall, 1);
      step();
      chk("conf_bubble", fwd_sel, 0);

      // ---------------- zero register ----------------
      idle();
      ex_valid = 1; ex_rd = 5'd0; ex_wr = 1; ex_is_load = 1;
      mem_valid = 1; mem_rd = 5'd0; mem_wr = 1;
      wb_valid = 1; wb_rd = 5'd0; wb_wr = 1;
      id_valid = 1; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11; id_wr = 1; id_rd = 5'd0;
      #1 chk("r0_stall", stall, 0);
      step();
      idle();
      #1 chk("r0_sel", fwd_sel, 0);

      // ---------------- miss then fill ----------------
      idle(); miss_valid = 1; miss_rd = 5'd9;
      step();
      idle();
      chk("miss_count", dut.r_count, 1);
      chk("miss_busy9", dut.r_busy[9], 1);
      step();
      id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1 chk("raw_stall", stall, 1);
         step();
      end
      fill_valid = 1; fill_rd = 5'd9; fill_data = 32'hBEEF;
      #1 chk("fill_release", stall, 0);
      step();
      idle();
      #1 chk("fill_sel", fwd_sel[1:0], 3);
      chk("fill_data", fwd_data[31:0], 32'hBEEF);
      chk("fill_busy9", dut.r_busy[9], 0);
      chk("fill_count", dut.r_count, 0);

      // ---------------- capacity ----------------
      for (int r = 1; r <= 4; r++) begin
         idle(); miss_valid = 1; miss_rd = 5'(r);
         step();
      end
      idle();
      #1 chk("cap_pfull", pending_full, 1);
      chk("cap_count4", dut.r_count, 4);
      chk("cap_err0", err, 0);
      miss_valid = 1; miss_rd = 5'd5;
      step();
      idle();
      #1 chk("ovf_err", err, 1);
      chk("ovf_count", dut.r_count, 4);
      chk("ovf_busy5", dut.r_busy[5], 0);
      fill_valid = 1; fill_rd = 5'd4;
      step();
      idle();
      #1 chk("fill4_count", dut.r_count, 3);
      chk("fill4_pfull", pending_full, 0);
      miss_valid = 1; miss_rd = 5'd6; fill_valid = 1; fill_rd = 5'd1;
      step();
      idle();
      #1 chk("mf_count", dut.r_count, 3);
      chk("mf_busy6", dut.r_busy[6], 1);
      chk("mf_busy1", dut.r_busy[1], 0);
      miss_valid = 1; miss_rd = 5'd0;
      step();
      idle();
      #1 chk("miss0_count", dut.r_count, 3);

      // ---------------- WAW ----------------
      id_valid = 1; id_wr = 1; id_rd = 5'd2;
      #1 chk("waw_stall", stall, 1);
      fill_valid = 1; fill_rd = 5'd2;
      #1 chk("waw_fill", stall, 0);
      step();
      idle();
      #1 chk("waw_count", dut.r_count, 2);
      chk("err_sticky", err, 1);

      // ---------------- reset mid-miss ----------------
      id_valid = 1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
      #1 chk("pre_rst_stall", stall, 1);
      rst = 1;
      #1 chk("in_rst_stall", stall, 0);
      step();
      rst = 0;
      #1 chk("post_rst_stall", stall, 0);
      chk("post_rst_count", dut.r_count, 0);
      chk("post_rst_busy", dut.r_busy, 0);
      chk("post_rst_sel", fwd_sel, 0);
      chk("post_rst_err", err, 0);
      chk("post_rst_pfull", pending_full, 0);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule : tb_bypass_scoreboard
`default_nettype wire
